// File: rtl/inst_load_sequencer.sv
// Loads the instruction memory from a valid/ready stream, then optionally starts the core and tracks it until it finishes.
// Optional feature: define INST_LOAD_CHECKSUM_EN to add chksum_o, the XOR of the words accepted in the current load.
module inst_load_sequencer #(
   parameter int unsigned  RegAddrWidth     = 32,
   parameter int unsigned  InstMemDepth     = 128,
   localparam int unsigned InstMemAddrWidth = $clog2(InstMemDepth)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clr_i,
   input  logic                        load_req_i,
   input  logic [InstMemAddrWidth-1:0] cfg_start_addr_i,
   input  logic [InstMemAddrWidth:0]   cfg_num_inst_i,
   input  logic                        cfg_autostart_i,
   input  logic [RegAddrWidth-1:0]     inst_data_i,
   input  logic                        inst_valid_i,
   output logic                        inst_ready_o,
   output logic                        inst_wr_mode_o,
   output logic [InstMemAddrWidth-1:0] inst_wr_addr_o,
   output logic                        inst_wr_addr_en_o,
   output logic [RegAddrWidth-1:0]     inst_wr_data_o,
   output logic                        inst_wr_data_en_o,
   output logic                        inst_pc_reset_o,
   output logic                        core_start_o,
   input  logic                        core_enable_i,
`ifdef INST_LOAD_CHECKSUM_EN
   output logic [RegAddrWidth-1:0]     chksum_o,
`endif
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o
);

   localparam logic [InstMemAddrWidth:0] DepthW = (InstMemAddrWidth+1)'(InstMemDepth);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StLoad,
      StFinish,
      StStart,
      StWaitEn,
      StRun
   } state_e;

   state_e                      state_q, state_d;
   logic [InstMemAddrWidth-1:0] cnt_q, cnt_d;
   logic [InstMemAddrWidth-1:0] start_q, start_d;
   logic [InstMemAddrWidth:0]   num_q, num_d;
   logic                        auto_q, auto_d;
   logic                        done_q, done_d;
   logic                        err_q, err_d;
   logic [InstMemAddrWidth:0]   range_end;
   logic                        reject;
   logic                        handshake;
   logic                        last_word;
`ifdef INST_LOAD_CHECKSUM_EN
   logic [RegAddrWidth-1:0]     chk_q, chk_d;
`endif

   // Range is checked at IMAW+1 bits so start+num == depth is still representable.
   assign range_end = {1'b0, cfg_start_addr_i} + cfg_num_inst_i;
   assign reject    = (cfg_num_inst_i == '0) || (range_end > DepthW);
   assign handshake = inst_valid_i && (state_q == StLoad);
   assign last_word = ({1'b0, cnt_q} == (num_q - 1'b1));

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_d = start_q;
      num_d   = num_q;
      auto_d  = auto_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
`ifdef INST_LOAD_CHECKSUM_EN
      chk_d   = chk_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (load_req_i) begin
               if (reject) begin
                  err_d = 1'b1;
               end else begin
                  start_d = cfg_start_addr_i;
                  num_d   = cfg_num_inst_i;
                  auto_d  = cfg_autostart_i;
                  cnt_d   = '0;
                  state_d = StAddr;
`ifdef INST_LOAD_CHECKSUM_EN
                  chk_d   = '0;
`endif
               end
            end
         end
         StAddr:   state_d = StLoad;
         StLoad: begin
            if (handshake) begin
`ifdef INST_LOAD_CHECKSUM_EN
               chk_d = chk_q ^ inst_data_i;
`endif
               if (last_word) begin
                  cnt_d   = '0;
                  state_d = StFinish;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StFinish: begin
            if (auto_q) begin
               state_d = StStart;
            end else begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         StStart:  state_d = StWaitEn;
         StWaitEn: if (core_enable_i) state_d = StRun;
         StRun: begin
            if (!core_enable_i) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default:  state_d = StIdle;
      endcase

      // Synchronous clear abandons any load in flight without signalling completion.
      if (clr_i) begin
         state_d = StIdle;
         cnt_d   = '0;
         done_d  = 1'b0;
         err_d   = 1'b0;
`ifdef INST_LOAD_CHECKSUM_EN
         chk_d   = '0;
`endif
      end
   end

   always_comb begin
      inst_ready_o      = 1'b0;
      inst_wr_mode_o    = 1'b0;
      inst_wr_addr_o    = '0;
      inst_wr_addr_en_o = 1'b0;
      inst_pc_reset_o   = 1'b0;
      core_start_o      = 1'b0;
      busy_o            = (state_q != StIdle);
      done_o            = done_q;
      err_o             = err_q;
      unique case (state_q)
         StAddr: begin
            inst_wr_mode_o    = 1'b1;
            inst_wr_addr_en_o = 1'b1;
            inst_wr_addr_o    = start_q;
         end
         StLoad: begin
            inst_wr_mode_o = 1'b1;
            inst_ready_o   = 1'b1;
         end
         StFinish: inst_pc_reset_o = 1'b1;
         StStart:  core_start_o    = 1'b1;
         default: ;
      endcase
   end

   assign inst_wr_data_o    = inst_data_i;
   assign inst_wr_data_en_o = handshake;
`ifdef INST_LOAD_CHECKSUM_EN
   assign chksum_o          = chk_q;
`endif

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         start_q <= '0;
         num_q   <= '0;
         auto_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef INST_LOAD_CHECKSUM_EN
         chk_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         num_q   <= num_d;
         auto_q  <= auto_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef INST_LOAD_CHECKSUM_EN
         chk_q   <= chk_d;
`endif
      end
   end

endmodule
